// File: rtl/icache_pkg.sv
// Shared definitions for the N-way instruction cache.
// Contents: refill FSM state encoding, AXI constants, geometry helpers.
package icache_pkg;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} icache_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // 32-bit words per line for a given log2(bytes/line).
    function automatic int unsigned words_of(input int unsigned line_width);
        return 32'd1 << (line_width - 32'd2);
    endfunction

    function automatic int unsigned tag_width_of(input int unsigned addr_width,
                                                 input int unsigned line_width,
                                                 input int unsigned set_width);
        return addr_width - line_width - set_width;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid bits, tags and line data.
// Ports: clk/rst; lookup read port (rd_set/rd_word -> rd_valid/rd_tag/rd_data);
//   invalidate probe port (inv_set -> inv_valid/inv_tag); refill data write (wr_en, line_set,
//   wr_word, wr_data); line validate (set_valid, line_set, set_tag); single-line clear
//   (clr_line, clr_set); flush_all clears every valid bit.
module icache_way #(
    parameter int unsigned SET_WIDTH = 6,
    parameter int unsigned WORD_BITS = 4,
    parameter int unsigned TAG_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SET_WIDTH-1:0] rd_set,
    input  logic [WORD_BITS-1:0] rd_word,
    output logic                 rd_valid,
    output logic [TAG_WIDTH-1:0] rd_tag,
    output logic [31:0]          rd_data,
    input  logic [SET_WIDTH-1:0] inv_set,
    output logic                 inv_valid,
    output logic [TAG_WIDTH-1:0] inv_tag,
    input  logic                 wr_en,
    input  logic [SET_WIDTH-1:0] line_set,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [31:0]          wr_data,
    input  logic                 set_valid,
    input  logic [TAG_WIDTH-1:0] set_tag,
    input  logic                 clr_line,
    input  logic [SET_WIDTH-1:0] clr_set,
    input  logic                 flush_all
);
    localparam int unsigned SETS  = 32'd1 << SET_WIDTH;
    localparam int unsigned WORDS = 32'd1 << WORD_BITS;

    logic [SETS-1:0]      valid_q;
    logic [TAG_WIDTH-1:0] tag_q  [SETS];
    logic [31:0]          data_q [SETS][WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else begin
            if (clr_line)  valid_q[clr_set]  <= 1'b0;
            if (set_valid) valid_q[line_set] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (set_valid) tag_q[line_set]           <= set_tag;
        if (wr_en)     data_q[line_set][wr_word] <= wr_data;
    end

    assign rd_valid  = valid_q[rd_set];
    assign rd_tag    = tag_q[rd_set];
    assign rd_data   = data_q[rd_set][rd_word];
    assign inv_valid = valid_q[inv_set];
    assign inv_tag   = tag_q[inv_set];

endmodule

// File: rtl/inst_cache_nway.sv
// Read-only WAYS-way set-associative instruction cache with AXI INCR line refill.
// Ports: clk, rst (async, active-high); fetch side read_en/addr_read -> ready/data_out;
//   flush, hit_invalidate/addr_inv maintenance; bus_error pulse; AXI AR and R channels.
// Optional macro ICACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module inst_cache_nway
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 6,
    parameter int unsigned SET_WIDTH  = 6,
    parameter int unsigned WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] addr_read,
    output logic                  ready,
    output logic [31:0]           data_out,
    input  logic                  flush,
    input  logic                  hit_invalidate,
    input  logic [ADDR_WIDTH-1:0] addr_inv,
    output logic                  bus_error,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    output logic [3:0]            arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);
    localparam int unsigned WORDS     = words_of(LINE_WIDTH);
    localparam int unsigned WORD_BITS = LINE_WIDTH - 2;
    localparam int unsigned TAG_WIDTH = tag_width_of(ADDR_WIDTH, LINE_WIDTH, SET_WIDTH);
    localparam int unsigned SETS      = 32'd1 << SET_WIDTH;
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

    icache_state_e        state_q, state_d;
    logic [WAY_BITS-1:0]  victim_q, victim;
    logic [SET_WIDTH-1:0] refill_set_q;
    logic [TAG_WIDTH-1:0] refill_tag_q;
    logic [WORD_BITS-1:0] word_cnt_q;
    logic                 err_q, flush_pend_q;
    logic [WAY_BITS-1:0]  rr_q [SETS];

    logic [SET_WIDTH-1:0] lk_set, inv_set, clr_set;
    logic [WORD_BITS-1:0] lk_word;
    logic [TAG_WIDTH-1:0] lk_tag, inv_tag;
    logic [WAYS-1:0]      way_valid, way_inv_valid, inv_match;
    logic [WAYS-1:0]      way_wr, way_set, way_clr;
    logic [TAG_WIDTH-1:0] way_tag [WAYS];
    logic [TAG_WIDTH-1:0] way_inv_tag [WAYS];
    logic [31:0]          way_data [WAYS];
    logic                 hit, found, start_miss, flush_now, flush_all;
    logic [31:0]          hit_data;
    logic                 unused_bits;

    assign lk_set  = addr_read[LINE_WIDTH +: SET_WIDTH];
    assign lk_word = addr_read[2 +: WORD_BITS];
    assign lk_tag  = addr_read[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign inv_set = addr_inv[LINE_WIDTH +: SET_WIDTH];
    assign inv_tag = addr_inv[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign unused_bits = ^{addr_read[1:0], addr_inv[LINE_WIDTH-1:0], rid};

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SET_WIDTH(SET_WIDTH),
            .WORD_BITS(WORD_BITS),
            .TAG_WIDTH(TAG_WIDTH)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .rd_set   (lk_set),
            .rd_word  (lk_word),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w]),
            .inv_set  (inv_set),
            .inv_valid(way_inv_valid[w]),
            .inv_tag  (way_inv_tag[w]),
            .wr_en    (way_wr[w]),
            .line_set (refill_set_q),
            .wr_word  (word_cnt_q),
            .wr_data  (rdata),
            .set_valid(way_set[w]),
            .set_tag  (refill_tag_q),
            .clr_line (way_clr[w]),
            .clr_set  (clr_set),
            .flush_all(flush_all)
        );
    end

    // Lookup, invalidate probe and victim choice (lowest invalid way, else round-robin).
    always_comb begin
        hit       = 1'b0;
        hit_data  = '0;
        inv_match = '0;
        victim    = rr_q[lk_set];
        found     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == lk_tag)) begin
                hit      = 1'b1;
                hit_data = hit_data | way_data[w];
            end
            inv_match[w] = way_inv_valid[w] && (way_inv_tag[w] == inv_tag);
            if (!found && !way_valid[w]) begin
                victim = WAY_BITS'(w);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (read_en && !hit && !hit_invalidate && !flush_pend_q) begin
                    start_miss = 1'b1;
                    state_d    = StAddr;
                end
            end
            StAddr: if (arready) state_d = StData;
            StData: if (rvalid && rlast) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A flush landing in DONE itself is honoured there rather than deferred.
    assign flush_now = flush_pend_q || flush;
    assign flush_all = ((state_q == StIdle) && flush) || ((state_q == StDone) && flush_now);

    // The victim is invalidated as the refill starts: its data is overwritten by the burst,
    // so it must not survive a failed or flushed refill.
    always_comb begin
        clr_set = lk_set;
        for (int w = 0; w < WAYS; w++) begin
            way_wr[w]  = (state_q == StData) && rvalid && (victim_q == WAY_BITS'(w));
            way_set[w] = (state_q == StDone) && !err_q && !flush_now
                         && (victim_q == WAY_BITS'(w));
            way_clr[w] = start_miss && (victim == WAY_BITS'(w));
        end
        if ((state_q == StIdle) && hit_invalidate && !flush) begin
            clr_set = inv_set;
            way_clr = inv_match;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            victim_q     <= '0;
            refill_set_q <= '0;
            refill_tag_q <= '0;
            word_cnt_q   <= '0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (start_miss) begin
                victim_q     <= victim;
                refill_set_q <= lk_set;
                refill_tag_q <= lk_tag;
                word_cnt_q   <= '0;
                err_q        <= 1'b0;
            end
            if ((state_q == StData) && rvalid) begin
                word_cnt_q <= word_cnt_q + 1'b1;
                if (rresp != RESP_OKAY) err_q <= 1'b1;
            end
            if ((state_q != StIdle) && flush) flush_pend_q <= 1'b1;
            if (state_q == StDone) begin
                flush_pend_q <= 1'b0;
                if (!err_q && !flush_now) begin
                    rr_q[refill_set_q] <= (rr_q[refill_set_q] == WAY_BITS'(WAYS - 1)) ?
                                          '0 : rr_q[refill_set_q] + 1'b1;
                end
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ready)      hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (start_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign ready     = (state_q == StIdle) && read_en && hit;
    assign data_out  = ready ? hit_data : 32'd0;
    assign bus_error = (state_q == StDone) && err_q;
    assign arvalid   = (state_q == StAddr);
    assign araddr    = {refill_tag_q, refill_set_q, LINE_WIDTH'(0)};
    assign arid      = 4'd0;
    assign arlen     = 8'(WORDS - 1);
    assign arsize    = SIZE_4B;
    assign arburst   = BURST_INCR;
    assign arlock    = 1'b0;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;
    assign rready    = 1'b1;

endmodule

// File: tb/tb_inst_cache_nway.sv
module tb_inst_cache_nway;
    localparam int unsigned LW = 6, SW = 6, NW = 2, TW = 20;
    localparam int unsigned WORDS = 16, SETS = 64, MAX_CYC = 400;

    logic clk = 1'b0, rst = 1'b1;
    logic read_en = 0, flush = 0, hit_invalidate = 0;
    logic [31:0] addr_read = '0, addr_inv = '0;
    logic ready, bus_error, arlock, arvalid, rready;
    logic [31:0] data_out, araddr;
    logic [3:0] arid, arcache;
    logic [7:0] arlen;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst;
    logic arready = 0, rlast = 0, rvalid = 0;
    logic [3:0] rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0] rresp = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    inst_cache_nway #(.ADDR_WIDTH(32), .LINE_WIDTH(LW), .SET_WIDTH(SW), .WAYS(NW)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .addr_read(addr_read), .ready(ready),
        .data_out(data_out), .flush(flush), .hit_invalidate(hit_invalidate),
        .addr_inv(addr_inv), .bus_error(bus_error),
`ifdef ICACHE_PERF_CNT_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .araddr(araddr), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mk_addr(input int unsigned tag, input int unsigned set,
                                            input int unsigned word);
        return 32'((tag << 12) | (set << 6) | (word << 2));
    endfunction

    // Reference model: each set holds up to NW tags; fills go to the lowest empty slot,
    // otherwise the slot named by the set's round-robin pointer.
    bit          m_vld [SETS][NW];
    logic [TW-1:0] m_tag [SETS][NW];
    int          m_rr  [SETS];

    function automatic int set_of(input logic [31:0] a);
        return int'(a[LW +: SW]);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        for (int w = 0; w < NW; w++)
            if (m_vld[set_of(a)][w] && m_tag[set_of(a)][w] == a[31 -: TW]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_victim(input logic [31:0] a);
        for (int w = 0; w < NW; w++) if (!m_vld[set_of(a)][w]) return w;
        return m_rr[set_of(a)];
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int v = m_victim(a);
        int s = set_of(a);
        m_vld[s][v] = 1'b1;
        m_tag[s][v] = a[31 -: TW];
        m_rr[s] = (m_rr[s] + 1) % NW;
    endfunction

    function automatic void m_drop(input logic [31:0] a);
        m_vld[set_of(a)][m_victim(a)] = 1'b0;
    endfunction

    function automatic void m_inval(input logic [31:0] a);
        for (int w = 0; w < NW; w++)
            if (m_tag[set_of(a)][w] == a[31 -: TW]) m_vld[set_of(a)][w] = 1'b0;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < NW; w++) m_vld[s][w] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_flush();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    endfunction

    // Holds read_en until ready, acting as the AXI slave. Fault injection (error beat,
    // flush beat, reset beat) applies to the first burst only.
    task automatic fetch(input logic [31:0] a, input int err_beat, input int flush_beat,
                         input int rst_beat, output logic [31:0] d, output int lat,
                         output int n_ar, output logic [31:0] ar_addr,
                         output logic [7:0] ar_len, output int be_cnt);
        int sent;
        bit active, done;
        logic [31:0] base;
        d = '0; lat = -1; n_ar = 0; ar_addr = '0; ar_len = '0; be_cnt = 0;
        sent = 0; active = 0; done = 0; base = '0;
        read_en = 1'b1; addr_read = a;
        for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
            @(negedge clk);
            if (bus_error) be_cnt++;
            rvalid = 0; rlast = 0; rresp = 2'b00; flush = 0; arready = 0;
            if (ready) begin
                d = data_out; lat = cyc; done = 1;
            end else begin
                if (active && $urandom_range(0, 3) != 0) begin
                    if (n_ar == 1 && sent == rst_beat) begin
                        rst = 1'b1; done = 1; active = 0;
                    end else begin
                        rvalid = 1'b1;
                        rdata = mem_word(base + 32'(sent * 4));
                        rlast = (sent == WORDS - 1);
                        rid = 4'd0;
                        if (n_ar == 1 && sent == err_beat) rresp = 2'b10;
                        if (n_ar == 1 && sent == flush_beat) flush = 1'b1;
                        sent++;
                        if (sent == WORDS) active = 0;
                    end
                end
                if (arvalid && !done) begin
                    ar_addr = araddr; ar_len = arlen;
                    if ($urandom_range(0, 2) != 0) begin
                        arready = 1'b1; n_ar++; active = 1; sent = 0; base = araddr;
                    end
                end
            end
        end
        read_en = 1'b0;
        check("fetch_done", 32'(done), 32'd1);
    endtask

    task automatic fetch_chk(input string nm, input logic [31:0] a);
        logic [31:0] d, ara;
        logic [7:0] arl;
        int lat, nar, be;
        bit eh;
        eh = m_hit(a);
        fetch(a, -1, -1, -1, d, lat, nar, ara, arl, be);
        check({nm, "_data"}, d, mem_word(a));
        check({nm, "_nar"}, 32'(nar), eh ? 32'd0 : 32'd1);
        check({nm, "_berr"}, 32'(be), 32'd0);
        if (eh) check({nm, "_lat"}, 32'(lat), 32'd0);
        if (!eh) m_fill(a);
    endtask

    task automatic pulse_inval(input logic [31:0] a);
        hit_invalidate = 1'b1; addr_inv = a;
        @(negedge clk);
        hit_invalidate = 1'b0;
        m_inval(a);
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        exp_hit;
    } vec_t;
    vec_t vecs [11];

    initial begin
        logic [31:0] d, ara, a_a, a_b, a_c, a_d, a_e;
        logic [7:0] arl;
        int lat, nar, be;

        a_a = mk_addr(1, 5, 0); a_b = mk_addr(2, 5, 3); a_c = mk_addr(3, 5, 9);
        a_d = mk_addr(4, 5, 2); a_e = mk_addr(5, 7, 1);
        vecs[0]  = '{addr: 32'h1000_0040, exp_hit: 1'b0};
        vecs[1]  = '{addr: 32'h1000_0044, exp_hit: 1'b1};
        vecs[2]  = '{addr: 32'h1000_007C, exp_hit: 1'b1};
        vecs[3]  = '{addr: a_a, exp_hit: 1'b0};
        vecs[4]  = '{addr: a_b, exp_hit: 1'b0};
        vecs[5]  = '{addr: a_a, exp_hit: 1'b1};
        vecs[6]  = '{addr: a_c, exp_hit: 1'b0};  // evicts A (way 0)
        vecs[7]  = '{addr: a_b, exp_hit: 1'b1};
        vecs[8]  = '{addr: a_a, exp_hit: 1'b0};  // evicts B (way 1)
        vecs[9]  = '{addr: a_c, exp_hit: 1'b1};
        vecs[10] = '{addr: a_b, exp_hit: 1'b0};  // evicts C (way 0)
        m_reset();

        // Reset state and fixed AXI fields.
        read_en = 1'b1; addr_read = 32'h1000_0040;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_berr", 32'(bus_error), 32'd0);
        check("arsize", 32'(arsize), 32'd2);
        check("arburst", 32'(arburst), 32'd1);
        check("arid", 32'(arid), 32'd0);
        check("arlen", 32'(arlen), 32'd15);
        check("rready", 32'(rready), 32'd1);
`ifdef ICACHE_PERF_CNT_EN
        check("rst_hitcnt", hit_count, 32'd0);
        check("rst_misscnt", miss_count, 32'd0);
`endif
        read_en = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Directed table: cold miss, 0-cycle hits, round-robin eviction in set 5.
        for (int i = 0; i < 11; i++) begin
            fetch(vecs[i].addr, -1, -1, -1, d, lat, nar, ara, arl, be);
            check($sformatf("vec%0d_data", i), d, mem_word(vecs[i].addr));
            check($sformatf("vec%0d_nar", i), 32'(nar), vecs[i].exp_hit ? 32'd0 : 32'd1);
            if (vecs[i].exp_hit) check($sformatf("vec%0d_lat", i), 32'(lat), 32'd0);
            else check($sformatf("vec%0d_araddr", i), ara, vecs[i].addr & 32'hFFFF_FFC0);
            if (i == 0) check("vec0_arlen", 32'(arl), 32'd15);
            if (!vecs[i].exp_hit) m_fill(vecs[i].addr);
        end

        // Invalidate present line, then absent line.
        pulse_inval(a_b);
        fetch_chk("inv_b", a_b);
        pulse_inval(mk_addr(9, 5, 0));
        fetch_chk("inv_absent_a", a_a);

        // Invalidate beats a miss start in the same cycle.
        read_en = 1'b1; addr_read = a_c; hit_invalidate = 1'b1; addr_inv = a_a;
        @(negedge clk);
        check("inv_prio_arvalid", 32'(arvalid), 32'd0);
        hit_invalidate = 1'b0; read_en = 1'b0;
        m_inval(a_a);
        @(negedge clk);
        fetch_chk("inv_prio_a", a_a);

        // Flush during beat 7: refill not validated, read retries, whole array cleared.
        fetch(a_d, -1, 7, -1, d, lat, nar, ara, arl, be);
        check("flushmid_nar", 32'(nar), 32'd2);
        check("flushmid_data", d, mem_word(a_d));
        m_flush(); m_fill(a_d);
        fetch_chk("flushmid_old", 32'h1000_0040);

        // Bus error on beat 3: one bus_error pulse, line stays invalid, AR re-issued.
        fetch(a_e, 3, -1, -1, d, lat, nar, ara, arl, be);
        check("berr_pulses", 32'(be), 32'd1);
        check("berr_nar", 32'(nar), 32'd2);
        check("berr_data", d, mem_word(a_e));
        m_drop(a_e); m_fill(a_e);
        fetch_chk("berr_hit", a_e);

        // Reset mid-burst; stray beats afterwards are ignored.
        fetch(mk_addr(6, 7, 0), -1, -1, 5, d, lat, nar, ara, arl, be);
        @(negedge clk);
        check("rstmid_arvalid", 32'(arvalid), 32'd0);
        check("rstmid_ready", 32'(ready), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check("rstmid_hitcnt", hit_count, 32'd0);
        check("rstmid_misscnt", miss_count, 32'd0);
`endif
        rst = 1'b0;
        rvalid = 1'b1; rlast = 1'b0; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rlast = 1'b1;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        m_reset();
        fetch_chk("rstmid_e", a_e);

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            int unsigned op;
            logic [31:0] ra;
            op = $urandom_range(0, 9);
            ra = mk_addr($urandom_range(1, 4), ($urandom_range(0, 1) != 0) ? 5 : 9,
                         $urandom_range(0, 15));
            if (op <= 6) begin
                fetch_chk("rnd", ra);
            end else if (op <= 8) begin
                pulse_inval(ra);
            end else begin
                flush = 1'b1; hit_invalidate = ($urandom_range(0, 1) != 0); addr_inv = ra;
                @(negedge clk);
                flush = 1'b0; hit_invalidate = 1'b0;
                m_flush();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
